memory_dbus_ctrl: RTL and testbench

//  Memory-stage data-bus controller, directly upstream of writeback. Turns the M-stage

---
 rtl/memory_dbus_ctrl.sv | 125 ++++++++++++
 tb/tb_memory_dbus_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_dbus_ctrl.sv
// Memory-stage data-bus controller: issues M-stage loads/stores as two-phase
// addr_ok/data_ok transactions and holds the returned dword for writeback.
module memory_dbus_ctrl #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [1:0]    msize,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  input  logic          advance,
  output logic          dreq_valid,
  output logic [AW-1:0] dreq_addr,
  output logic [1:0]    dreq_size,
  output logic [7:0]    dreq_strobe,
  output logic [DW-1:0] dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [DW-1:0] dresp_data,
  output logic [DW-1:0] rd,
  output logic          stall,
  output logic          misalign
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

  state_t        state, state_nx;
  logic          memacc;
  logic          memop;
  logic          rd_load;
  logic [7:0]    strobe_base;
  logic [7:0]    strobe_nx;
  logic [5:0]    byte_shift;

  assign memacc     = mem_valid & (memread | memwrite);
  assign memop      = memacc & ~misalign & ~flush;
  assign byte_shift = {addr[2:0], 3'b000};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    misalign    = 1'b0;
    strobe_base = 8'h00;
    unique case (msize)
      2'd0: begin strobe_base = 8'h01; misalign = 1'b0;          end
      2'd1: begin strobe_base = 8'h03; misalign = addr[0];       end
      2'd2: begin strobe_base = 8'h0F; misalign = |addr[1:0];    end
      default: begin strobe_base = 8'hFF; misalign = |addr[2:0]; end
    endcase
    misalign  = misalign & memacc;
    strobe_nx = memread ? 8'h00 : (strobe_base << addr[2:0]);
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset clears
  // the FSM, request fields and rd together so nothing stale survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dreq_addr   <= '0;
      dreq_size   <= 2'd0;
      dreq_strobe <= 8'h00;
      dreq_data   <= '0;
      rd          <= '0;
    end else begin
      state <= state_nx;
      // Request fields are captured once on issue and stay frozen until accepted.
      if (state == IDLE && memop) begin
        dreq_addr   <= {addr[AW-1:3], 3'b000};
        dreq_size   <= msize;
        dreq_strobe <= strobe_nx;
        dreq_data   <= wdata << byte_shift;
      end
      if (rd_load) rd <= dresp_data;
    end
  end

  always_comb begin
    state_nx   = state;
    rd_load    = 1'b0;
    dreq_valid = 1'b0;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        stall = memop;
        if (memop) state_nx = ADDR;
      end
      ADDR: begin
        dreq_valid = 1'b1;
        stall      = 1'b1;
        if (dresp_addr_ok && dresp_data_ok) begin
          rd_load  = 1'b1;
          state_nx = flush ? IDLE : DONE;
        end else if (dresp_addr_ok) begin
          state_nx = flush ? DRAIN : DATA;
        end else if (flush) begin
          // Withdrawing an unaccepted request is the only legal way to drop one.
          state_nx = IDLE;
        end
      end
      DATA: begin
        stall = 1'b1;
        if (dresp_data_ok) begin
          rd_load  = 1'b1;
          state_nx = flush ? IDLE : DONE;
        end else if (flush) begin
          state_nx = DRAIN;
        end
      end
      DONE: begin
        if (advance || flush) state_nx = IDLE;
      end
      DRAIN: begin
        // Squashed transaction: swallow the response without touching rd.
        stall = memop;
        if (dresp_data_ok) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_dbus_ctrl.sv
// Directed self-checking bench for memory_dbus_ctrl; inputs change just after
// the falling edge and outputs are sampled 1ns later.
module tb_memory_dbus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, memread, memwrite, flush, advance;
  logic [1:0]  msize;
  logic [63:0] addr, wdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic [63:0] rd;
  logic        stall, misalign;

  int tests = 0;
  int fails = 0;
  int sc;
  logic [63:0] exp_rd;

  memory_dbus_ctrl #(.AW(64), .DW(64)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .memread(memread),
    .memwrite(memwrite), .msize(msize), .addr(addr), .wdata(wdata),
    .flush(flush), .advance(advance), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .rd(rd),
    .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_op(input logic rdn, input logic wr, input logic [1:0] sz,
                        input logic [63:0] a, input logic [63:0] wd);
    mem_valid = 1'b1; memread = rdn; memwrite = wr; msize = sz; addr = a; wdata = wd;
  endtask

  task automatic clear_in();
    mem_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; flush = 1'b0; advance = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_in(); msize = 2'd0; addr = '0; wdata = '0; dresp_data = '0;
    cyc(); cyc(); #1;
    tests++; if (dreq_valid !== 1'b0) begin fails++; $display("FAIL rst_dreq_valid: got %b want 0", dreq_valid); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall); end
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b want 0", misalign); end
    tests++; if (rd !== 64'h0) begin fails++; $display("FAIL rst_rd: got %h want 0", rd); end
    tests++; if ({dreq_addr, dreq_data, dreq_strobe, dreq_size} !== '0) begin fails++; $display("FAIL rst_req_regs: got %h/%h/%h/%h want 0", dreq_addr, dreq_data, dreq_strobe, dreq_size); end
    cyc(); reset = 1'b0; exp_rd = 64'h0;
  endtask

  task automatic test_load_dword();
    sc = 0;
    cyc(); set_op(1'b1, 1'b0, 2'd3, 64'h8000_0008, 64'h0); #1;
    sc += int'(stall);
    tests++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin fails++; $display("FAIL ld64_issue: got stall=%b valid=%b want 1/0", stall, dreq_valid); end
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h1122_3344_5566_7788; #1;
    sc += int'(stall);
    tests++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0008 || dreq_size !== 2'd3) begin fails++; $display("FAIL ld64_req: got valid=%b addr=%h size=%0d want 1/80000008/3", dreq_valid, dreq_addr, dreq_size); end
    tests++; if (dreq_strobe !== 8'h00) begin fails++; $display("FAIL ld64_strobe: got %h want 00", dreq_strobe); end
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; advance = 1'b1; #1;
    sc += int'(stall);
    exp_rd = 64'h1122_3344_5566_7788;
    tests++; if (rd !== exp_rd) begin fails++; $display("FAIL ld64_rd: got %h want %h", rd, exp_rd); end
    tests++; if (sc !== 2 || dreq_valid !== 1'b0) begin fails++; $display("FAIL ld64_stall_cycles: got %0d valid=%b want 2/0", sc, dreq_valid); end
    cyc(); clear_in(); #1;
    tests++; if (rd !== exp_rd || stall !== 1'b0) begin fails++; $display("FAIL ld64_rd_hold: got %h stall=%b want %h/0", rd, stall, exp_rd); end
  endtask

  task automatic test_store_byte();
    cyc(); set_op(1'b0, 1'b1, 2'd0, 64'h8000_0005, 64'hAB); #1;
    tests++; if (stall !== 1'b1 || misalign !== 1'b0) begin fails++; $display("FAIL sb_issue: got stall=%b mis=%b want 1/0", stall, misalign); end
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h5555; #1;
    tests++; if (dreq_addr !== 64'h8000_0000) begin fails++; $display("FAIL sb_addr: got %h want 80000000", dreq_addr); end
    tests++; if (dreq_strobe !== 8'h20) begin fails++; $display("FAIL sb_strobe: got %h want 20", dreq_strobe); end
    tests++; if (dreq_data !== 64'h0000_AB00_0000_0000) begin fails++; $display("FAIL sb_data: got %h want 0000ab0000000000", dreq_data); end
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; advance = 1'b1; #1;
    exp_rd = 64'h5555;
    tests++; if (rd !== exp_rd || stall !== 1'b0) begin fails++; $display("FAIL sb_done: got rd=%h stall=%b want %h/0", rd, stall, exp_rd); end
    cyc(); clear_in(); #1;
  endtask

  task automatic test_back_to_back();
    cyc(); set_op(1'b0, 1'b1, 2'd1, 64'h8000_0036, 64'h1234); #1;
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h42; #1;
    tests++; if (dreq_strobe !== 8'hC0 || dreq_data !== 64'h1234_0000_0000_0000 || dreq_addr !== 64'h8000_0030) begin fails++; $display("FAIL b2b_sh: got strb=%h data=%h addr=%h want c0/1234000000000000/80000030", dreq_strobe, dreq_data, dreq_addr); end
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; advance = 1'b1; #1;
    tests++; if (stall !== 1'b0 || rd !== 64'h42) begin fails++; $display("FAIL b2b_done1: got stall=%b rd=%h want 0/42", stall, rd); end
    cyc(); advance = 1'b0; set_op(1'b0, 1'b1, 2'd2, 64'h8000_0044, 64'hCAFE_BABE); #1;
    tests++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle2: got stall=%b valid=%b want 1/0", stall, dreq_valid); end
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h99; #1;
    tests++; if (dreq_valid !== 1'b1 || dreq_strobe !== 8'hF0 || dreq_data !== 64'hCAFE_BABE_0000_0000 || dreq_addr !== 64'h8000_0040 || dreq_size !== 2'd2) begin fails++; $display("FAIL b2b_sw: got v=%b strb=%h data=%h addr=%h size=%0d want 1/f0/cafebabe00000000/80000040/2", dreq_valid, dreq_strobe, dreq_data, dreq_addr, dreq_size); end
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; advance = 1'b1; #1;
    exp_rd = 64'h99;
    tests++; if (rd !== exp_rd || stall !== 1'b0) begin fails++; $display("FAIL b2b_done2: got rd=%h stall=%b want %h/0", rd, stall, exp_rd); end
    cyc(); clear_in(); #1;
  endtask

  task automatic test_load_word_delay();
    sc = 0;
    cyc(); set_op(1'b1, 1'b0, 2'd2, 64'h8000_0010, 64'h0); #1;
    sc += int'(stall);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 1) begin addr = 64'h8000_0020; msize = 2'd0; end
      if (i == 2) dresp_addr_ok = 1'b1;
      #1;
      sc += int'(stall);
      tests++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0010 || dreq_size !== 2'd2 || dreq_strobe !== 8'h00) begin fails++; $display("FAIL lw_addr_stable%0d: got v=%b addr=%h size=%0d strb=%h want 1/80000010/2/00", i, dreq_valid, dreq_addr, dreq_size, dreq_strobe); end
    end
    cyc(); dresp_addr_ok = 1'b0; #1;
    sc += int'(stall);
    tests++; if (dreq_valid !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL lw_data_wait: got v=%b stall=%b want 0/1", dreq_valid, stall); end
    cyc(); dresp_data_ok = 1'b1; dresp_data = 64'h0BAD_F00D_CAFE_0001; #1;
    sc += int'(stall);
    cyc(); dresp_data_ok = 1'b0; advance = 1'b1; #1;
    sc += int'(stall);
    exp_rd = 64'h0BAD_F00D_CAFE_0001;
    tests++; if (sc !== 6 || stall !== 1'b0) begin fails++; $display("FAIL lw_stall_cycles: got %0d stall=%b want 6/0", sc, stall); end
    tests++; if (rd !== exp_rd) begin fails++; $display("FAIL lw_rd: got %h want %h", rd, exp_rd); end
    cyc(); clear_in(); #1;
  endtask

  task automatic test_misalign();
    cyc(); set_op(1'b1, 1'b0, 2'd1, 64'h8000_0001, 64'h0); #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (misalign !== 1'b1 || dreq_valid !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL mis_half%0d: got mis=%b v=%b stall=%b want 1/0/0", i, misalign, dreq_valid, stall); end
      cyc(); #1;
    end
    msize = 2'd2; addr = 64'h8000_0002; #1;
    tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL mis_word: got %b want 1", misalign); end
    msize = 2'd3; addr = 64'h8000_0004; #1;
    tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL mis_dword: got %b want 1", misalign); end
    msize = 2'd0; addr = 64'h8000_0003; #1;
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL mis_byte: got %b want 0", misalign); end
    clear_in(); mem_valid = 1'b1; msize = 2'd1; addr = 64'h8000_0001;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      tests++; if (misalign !== 1'b0 || dreq_valid !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL nonmem%0d: got mis=%b v=%b stall=%b want 0/0/0", i, misalign, dreq_valid, stall); end
    end
    cyc(); clear_in(); #1;
  endtask

  task automatic test_flush();
    cyc(); set_op(1'b1, 1'b0, 2'd3, 64'h8000_0018, 64'h0); #1;
    cyc(); flush = 1'b1; #1;
    tests++; if (dreq_valid !== 1'b1) begin fails++; $display("FAIL fa_addr: got v=%b want 1", dreq_valid); end
    cyc(); clear_in(); #1;
    tests++; if (dreq_valid !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL fa_withdrawn: got v=%b stall=%b want 0/0", dreq_valid, stall); end
    cyc(); set_op(1'b1, 1'b0, 2'd3, 64'h8000_0018, 64'h0); #1;
    cyc(); dresp_addr_ok = 1'b1; #1;
    cyc(); dresp_addr_ok = 1'b0; flush = 1'b1; #1;
    tests++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin fails++; $display("FAIL fd_data: got stall=%b v=%b want 1/0", stall, dreq_valid); end
    cyc(); clear_in(); #1;
    tests++; if (stall !== 1'b0 || dreq_valid !== 1'b0 || rd !== exp_rd) begin fails++; $display("FAIL fd_drain: got stall=%b v=%b rd=%h want 0/0/%h", stall, dreq_valid, rd, exp_rd); end
    cyc(); dresp_data_ok = 1'b1; dresp_data = 64'hDEAD; set_op(1'b1, 1'b0, 2'd3, 64'h8000_0028, 64'h0); #1;
    tests++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin fails++; $display("FAIL fd_drain_memop: got stall=%b v=%b want 1/0", stall, dreq_valid); end
    cyc(); dresp_data_ok = 1'b0; #1;
    tests++; if (rd !== exp_rd || stall !== 1'b1 || dreq_valid !== 1'b0) begin fails++; $display("FAIL fd_discard: got rd=%h stall=%b v=%b want %h/1/0", rd, stall, dreq_valid, exp_rd); end
    cyc(); dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'h77; #1;
    tests++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_0028) begin fails++; $display("FAIL fd_reissue: got v=%b addr=%h want 1/80000028", dreq_valid, dreq_addr); end
    cyc(); dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; advance = 1'b1; #1;
    exp_rd = 64'h77;
    tests++; if (rd !== exp_rd || stall !== 1'b0) begin fails++; $display("FAIL fd_new_done: got rd=%h stall=%b want %h/0", rd, stall, exp_rd); end
    cyc(); clear_in(); #1;
  endtask

  task automatic test_reset_mid();
    cyc(); set_op(1'b1, 1'b0, 2'd3, 64'h8000_0030, 64'h0); #1;
    cyc(); dresp_addr_ok = 1'b1; #1;
    cyc(); dresp_addr_ok = 1'b0; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rm_in_data: got stall=%b want 1", stall); end
    reset = 1'b1; mem_valid = 1'b0; #1;
    exp_rd = 64'h0;
    tests++; if (stall !== 1'b0 || dreq_valid !== 1'b0 || rd !== exp_rd || dreq_addr !== 64'h0) begin fails++; $display("FAIL rm_async: got stall=%b v=%b rd=%h addr=%h want 0/0/0/0", stall, dreq_valid, rd, dreq_addr); end
    cyc(); reset = 1'b0; clear_in();
    cyc(); #1;
    tests++; if (stall !== 1'b0 || dreq_valid !== 1'b0 || rd !== exp_rd) begin fails++; $display("FAIL rm_after: got stall=%b v=%b rd=%h want 0/0/0", stall, dreq_valid, rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_dword();
    test_store_byte();
    test_back_to_back();
    test_load_word_delay();
    test_misalign();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
